writeback_merge: RTL and testbench

Writeback-stage merger sitting directly upstream of the decode-stage register file write port. It combines the in-order ALU result stream with the variable-latency memory/load result stream, buffers memory results in a small FIFO, and arbitrates onto the single write port (ra3/wd3/we3). It discards writes to register 31, which the register file maps to PC+16. A starvation guard stalls the ALU path so buffered loads always retire.

---
 rtl/writeback_merge.sv | 165 ++++++++++++++++
 tb/tb_writeback_merge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_merge.sv
// ---------------------------------------------------------------------------
// writeback_merge
//
// Merges the in-order ALU result stream and the variable-latency memory
// result stream onto the single register-file write port (ra3/wd3/we3).
// Memory results are buffered in a small circular FIFO. Writes to r31 are
// dropped because the register file maps r31 to PC+16. A starvation guard
// forces a one-cycle ALU stall so buffered loads always retire.
//
// Handshake (memory side): a transfer completes on any rising edge where
// mem_valid && mem_ready. mem_ready depends only on registered occupancy
// and rst, never on a same-cycle pop. The ALU side has no ready: while
// stall is high the upstream holds alu_valid/alu_rd/alu_data stable and
// the result is consumed in the following cycle.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid, alu_rd, alu_data    ALU result stream
//   mem_valid, mem_ready,
//   mem_rd, mem_data               memory result stream (valid/ready)
//   stall                          registered ALU hold request
//   we3, ra3, wd3                  registered register-file write port
//   fifo_count                     current memory FIFO occupancy
// ---------------------------------------------------------------------------
module writeback_merge #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [WIDTH-1:0]           alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [WIDTH-1:0]           mem_data,
  output logic                       stall,
  output logic                       we3,
  output logic [4:0]                 ra3,
  output logic [WIDTH-1:0]           wd3,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0] PC_REG = 5'd31;

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             we3_q, we3_d;
  logic [4:0]       ra3_q, ra3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;

  logic             full, empty;
  logic             push_hs, push_store;
  logic             alu_win, pop;
  logic [SW-1:0]    starve_inc;
  entry_t           head_entry;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign mem_ready  = !full && !rst;
  assign push_hs    = mem_valid && mem_ready;
  // r31 results complete the handshake but never occupy a slot.
  assign push_store = push_hs && (mem_rd != PC_REG);

  assign alu_win    = !stall_q && alu_valid;
  // Entries pushed this cycle are not visible here: no bypass.
  assign pop        = !alu_win && !empty;
  assign head_entry = fifo_q[head_q];
  assign starve_inc = starve_q + SW'(1);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;
    stall_d  = 1'b0;
    we3_d    = 1'b0;
    ra3_d    = ra3_q;
    wd3_d    = wd3_q;

    if (alu_win) begin
      we3_d = (alu_rd != PC_REG);
      ra3_d = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      we3_d  = 1'b1;
      ra3_d  = head_entry.rd;
      wd3_d  = head_entry.data;
      head_d = head_q + PW'(1);
    end

    if (push_store) begin
      tail_d = tail_q + PW'(1);
    end

    case ({push_store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Count ALU wins that leave a non-empty FIFO waiting; reaching the
    // limit requests a single stall cycle, during which the head pops.
    if (pop || empty || stall_q) begin
      starve_d = '0;
    end else if (alu_win) begin
      if (starve_inc == SW'(STARVE_LIMIT)) begin
        stall_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we3_q    <= 1'b0;
      ra3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we3_q    <= we3_d;
      ra3_q    <= ra3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push_store) begin
      fifo_q[tail_q] <= '{rd: mem_rd, data: mem_data};
    end
  end

  assign stall      = stall_q;
  assign we3        = we3_q;
  assign ra3        = ra3_q;
  assign wd3        = wd3_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_merge.sv
module tb_writeback_merge;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [W-1:0] alu_data;
  logic         mem_valid;
  logic         mem_ready;
  logic [4:0]   mem_rd;
  logic [W-1:0] mem_data;
  logic         stall;
  logic         we3;
  logic [4:0]   ra3;
  logic [W-1:0] wd3;
  logic [2:0]   fifo_count;

  int checks = 0;
  int errors = 0;

  // scoreboard of expected memory writes, {rd, data}
  logic [W+4:0] exp_q[$];

  writeback_merge #(.WIDTH(64), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .stall      (stall),
    .we3        (we3),
    .ra3        (ra3),
    .wd3        (wd3),
    .fifo_count (fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rst;
    logic         av;
    logic [4:0]   ard;
    logic [W-1:0] ad;
    logic         mv;
    logic [4:0]   mrd;
    logic [W-1:0] md;
    logic         e_ready;
    logic         e_we3;
    logic         chk_rw;
    logic [4:0]   e_ra3;
    logic [W-1:0] e_wd3;
    logic [2:0]   e_cnt;
    logic         e_stall;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                              input logic [W-1:0] ad, input logic mv, input logic [4:0] mrd,
                              input logic [W-1:0] md, input logic e_ready, input logic e_we3,
                              input logic chk_rw, input logic [4:0] e_ra3,
                              input logic [W-1:0] e_wd3, input logic [2:0] e_cnt,
                              input logic e_stall);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_ready = e_ready; v.e_we3 = e_we3; v.chk_rw = chk_rw; v.e_ra3 = e_ra3;
    v.e_wd3 = e_wd3; v.e_cnt = e_cnt; v.e_stall = e_stall;
    return v;
  endfunction

  // driver tasks
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard,
                       input logic [W-1:0] ad, input logic mv, input logic [4:0] mrd,
                       input logic [W-1:0] md);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_we3, input logic chk_rw,
                           input logic [4:0] e_ra3, input logic [W-1:0] e_wd3,
                           input logic [2:0] e_cnt, input logic e_stall);
    chk({tag, "_we3"}, W'(we3), W'(e_we3));
    if (chk_rw) begin
      chk({tag, "_ra3"}, W'(ra3), W'(e_ra3));
      chk({tag, "_wd3"}, wd3, e_wd3);
    end
    chk({tag, "_count"}, W'(fifo_count), W'(e_cnt));
    chk({tag, "_stall"}, W'(stall), W'(e_stall));
  endtask

  int mem_writes;

  initial begin
    drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    //        rst av  ard    ad          mv  mrd    md        rdy we3 rw  ra3    wd3         cnt stl
    vecs[0] = mk(1, 0, 5'd0,  64'h0,      1, 5'd3,  64'h55,   0,  0,  1,  5'd0,  64'h0,      0,  0);
    vecs[1] = mk(1, 0, 5'd0,  64'h0,      1, 5'd3,  64'h55,   0,  0,  1,  5'd0,  64'h0,      0,  0);
    vecs[2] = mk(0, 0, 5'd0,  64'h0,      0, 5'd0,  64'h0,    1,  0,  0,  5'd0,  64'h0,      0,  0);
    vecs[3] = mk(0, 1, 5'd5,  64'h1234,   0, 5'd0,  64'h0,    1,  1,  1,  5'd5,  64'h1234,   0,  0);
    vecs[4] = mk(0, 1, 5'd31, 64'h9999,   0, 5'd0,  64'h0,    1,  0,  0,  5'd0,  64'h0,      0,  0);
    vecs[5] = mk(0, 0, 5'd0,  64'h0,      1, 5'd7,  64'hAA,   1,  0,  0,  5'd0,  64'h0,      1,  0);
    vecs[6] = mk(0, 0, 5'd0,  64'h0,      0, 5'd0,  64'h0,    1,  1,  1,  5'd7,  64'hAA,     0,  0);
    vecs[7] = mk(0, 0, 5'd0,  64'h0,      1, 5'd31, 64'hBB,   1,  0,  0,  5'd0,  64'h0,      0,  0);
    vecs[8] = mk(0, 0, 5'd0,  64'h0,      0, 5'd0,  64'h0,    1,  0,  0,  5'd0,  64'h0,      0,  0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      #1;
      chk($sformatf("vec%0d_ready", i), W'(mem_ready), W'(vecs[i].e_ready));
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_we3, vecs[i].chk_rw, vecs[i].e_ra3,
                vecs[i].e_wd3, vecs[i].e_cnt, vecs[i].e_stall);
    end

    // Starvation: ALU busy every cycle while four loads fill the FIFO.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 4) drive(1'b0, 1'b1, 5'(i), 64'h100 + W'(i), 1'b1, 5'(19 + i), 64'hA0 + W'(i - 1));
      else        drive(1'b0, 1'b1, 5'(i), 64'h100 + W'(i), 1'b1, 5'd24, 64'hEE);
      #1;
      chk($sformatf("starve%0d_ready", i), W'(mem_ready), W'(i <= 4));
      tick();
      check_out($sformatf("starve%0d", i), 1'b1, 1'b1, 5'(i), 64'h100 + W'(i),
                (i <= 4) ? 3'(i) : 3'd4, i == 9);
    end
    // stall cycle: ALU input held, head pops, full FIFO still refuses
    drive(1'b0, 1'b1, 5'd10, 64'h10A, 1'b1, 5'd24, 64'hEE);
    #1;
    chk("stallcyc_ready", W'(mem_ready), W'(0));
    tick();
    check_out("stallcyc", 1'b1, 1'b1, 5'd20, 64'hA0, 3'd3, 1'b0);
    // held ALU result retires the cycle after the stall
    drive(1'b0, 1'b1, 5'd10, 64'h10A, 1'b0, 5'd0, '0);
    tick();
    check_out("held_alu", 1'b1, 1'b1, 5'd10, 64'h10A, 3'd3, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      tick();
      check_out($sformatf("drain%0d", j), 1'b1, 1'b1, 5'(21 + j), 64'hA1 + W'(j), 3'(2 - j), 1'b0);
    end
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
    check_out("drained", 1'b0, 1'b0, 5'd0, '0, 3'd0, 1'b0);

    // Wrap and ordering: ten pushes, ALU (rd 30) wins the first two cycles.
    mem_writes = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, c < 2, 5'd30, 64'hCAFE + W'(c), c < 10, 5'(c + 1), W'(c));
      #1;
      if (c < 10) begin
        chk($sformatf("wrap%0d_ready", c), W'(mem_ready), W'(1));
        exp_q.push_back({5'(c + 1), W'(c)});
      end
      tick();
      if (we3 && ra3 != 5'd30) begin
        mem_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wrap_extra: got write ra3=%0d wd3=0x%0h required none", ra3, wd3);
        end else begin
          chk($sformatf("wrap_order%0d", mem_writes), {ra3, wd3}, exp_q.pop_front());
        end
      end
      if (c >= 2 && c <= 9) chk($sformatf("pushpop_count%0d", c), W'(fifo_count), W'(2));
    end
    chk("wrap_total_writes", W'(mem_writes), W'(10));
    chk("wrap_queue_left", W'(exp_q.size()), W'(0));

    // Mid-operation reset during a stall with three entries buffered.
    for (int c = 1; c <= 9; c++) begin
      drive(1'b0, 1'b1, 5'd30, 64'h300 + W'(c), c <= 3, 5'(c), 64'hD0 + W'(c));
      tick();
    end
    chk("prereset_stall", W'(stall), W'(1));
    chk("prereset_count", W'(fifo_count), W'(3));
    drive(1'b1, 1'b1, 5'd30, 64'h30A, 1'b1, 5'd4, 64'hD4);
    #1;
    chk("midrst_ready", W'(mem_ready), W'(0));
    tick();
    check_out("midrst", 1'b0, 1'b1, 5'd0, 64'h0, 3'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      tick();
      check_out($sformatf("postrst%0d", c), 1'b0, 1'b0, 5'd0, '0, 3'd0, 1'b0);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
